fpga_cfg_loader: RTL

- Sequences the fabric configuration chain (ccff) of fpga_top from a byte stream delivered over the pin-limited TT3 input port.
- Generates prog_clk and drives ccff_head bit-serially, then checks the loopback on ccff_tail.
- Holds the fabric in reset while loading and releases it only after a verified load.
- Sits between the tt_um top-level pin mapping and fpga_top.

---
 rtl/fpga_cfg_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader
//
// Loads the fabric configuration chain (ccff) of fpga_top from a byte stream
// arriving over the narrow TT3 input port.
//
// How it works:
//   - Bytes are accepted one at a time over a valid/ready handshake.
//   - Each byte is shifted out MSB first on ccff_head_o, one bit per prog_clk
//     period.
//   - After CHAIN_LEN bits, the first bit of the stream must come back out of
//     ccff_tail_i.
//   - The fabric user logic is kept in reset until a load has been verified.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   rst_n          asynchronous active-low reset
//   start          one-cycle load request, ignored while busy
//   byte_in        configuration byte, shifted MSB first
//   byte_valid     byte_in holds a valid byte
//   byte_ready     loader accepts a byte (transfer on byte_valid && byte_ready)
//   prog_clk_o     configuration clock to fpga_top.prog_clk
//   ccff_head_o    serial configuration data to fpga_top.ccff_head
//   ccff_tail_i    chain output from fpga_top.ccff_tail
//   fabric_rst_n_o active-low reset to the fabric user logic
//   busy           load in progress
//   done           last load completed and verified (level)
//   err            last load failed the loopback check (level)
module fpga_cfg_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int CLK_DIV   = 2,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       prog_clk_o,
  output logic       ccff_head_o,
  input  logic       ccff_tail_i,
  output logic       fabric_rst_n_o,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CHAIN_BITS = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    VERIFY,
    DONE,
    FAIL
  } state_t;

  state_t           state;

  // The bit currently on ccff_head_o is held in the output register itself,
  // so the shift register only keeps the bits still waiting to go out.
  logic [6:0]       shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [3:0]       bits_left;
  logic [DIV_W-1:0] div_cnt;
  logic             first_bit;
  logic             verify_wait;

  assign bit_cnt_nxt = bit_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      bits_left      <= '0;
      div_cnt        <= '0;
      first_bit      <= 1'b0;
      verify_wait    <= 1'b0;
      byte_ready     <= 1'b0;
      prog_clk_o     <= 1'b0;
      ccff_head_o    <= 1'b0;
      fabric_rst_n_o <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        // A finished or failed load restarts exactly like a fresh one.
        // The fabric goes back into reset as soon as the new load begins.
        IDLE, DONE, FAIL: begin
          if (start) begin
            state          <= FETCH;
            done           <= 1'b0;
            err            <= 1'b0;
            busy           <= 1'b1;
            fabric_rst_n_o <= 1'b0;
            bit_cnt        <= '0;
            bits_left      <= '0;
            byte_ready     <= 1'b1;
          end
        end

        // Stall here with prog_clk low for as long as the source needs.
        FETCH: begin
          if (byte_valid && byte_ready) begin
            shreg       <= byte_in[6:0];
            ccff_head_o <= byte_in[7];
            bits_left   <= 4'd8;
            byte_ready  <= 1'b0;
            div_cnt     <= '0;
            state       <= SHIFT_LO;
            if (bit_cnt == '0) begin
              first_bit <= byte_in[7];
            end
          end
        end

        SHIFT_LO: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            prog_clk_o <= 1'b1;
            state      <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // The next bit is presented on the same edge that drops prog_clk,
        // so ccff_head_o never moves while prog_clk is high.
        // The chain-length test comes before the byte-empty test.
        // That way the unused tail bits of a partial last byte are dropped.
        SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            prog_clk_o <= 1'b0;
            shreg      <= {shreg[5:0], 1'b0};
            bit_cnt    <= bit_cnt_nxt;
            bits_left  <= bits_left - 1'b1;
            if (bit_cnt_nxt == CHAIN_BITS) begin
              verify_wait <= 1'b0;
              state       <= VERIFY;
            end else if (bits_left == 4'd1) begin
              byte_ready <= 1'b1;
              state      <= FETCH;
            end else begin
              ccff_head_o <= shreg[6];
              state       <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        // One settling cycle, then the tail should echo the first bit sent.
        VERIFY: begin
          if (!verify_wait) begin
            verify_wait <= 1'b1;
          end else begin
            busy <= 1'b0;
            if (ccff_tail_i == first_bit) begin
              done           <= 1'b1;
              fabric_rst_n_o <= 1'b1;
              state          <= DONE;
            end else begin
              err   <= 1'b1;
              state <= FAIL;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
